// File: rtl/iic_pkg.sv
// Shared types and the default sensor power-up table for the I2C config sequencer.
package iic_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RSP,
    ST_GAP,
    ST_DONE,
    ST_ERR
  } state_e;

  localparam logic [6:0] DEF_DEV_ADDR = 7'h76;
  localparam int         TABLE_LEN    = 9;

  // Entry 0 is the rightmost element: {reg_addr, data}.
  localparam logic [TABLE_LEN-1:0][15:0] REG_TABLE = {
    16'h3570, 16'h4818, 16'h1D43, 16'h2308, 16'h3660,
    16'h3416, 16'h3308, 16'h2109, 16'h49C0
  };

endpackage

// File: rtl/iic_cfg_rom.sv
// Combinational lookup of one register-table entry; unused indices read as zero.
module iic_cfg_rom
  import iic_pkg::*;
#(
  parameter int NUM_REGS = 9
) (
  input  logic [3:0] idx_i,
  output logic [7:0] reg_addr_o,
  output logic [7:0] data_o
);

  logic [15:0] entry;

  always_comb begin
    entry = 16'h0000;
    if (int'(idx_i) < NUM_REGS && int'(idx_i) < TABLE_LEN) begin
      entry = REG_TABLE[idx_i];
    end
  end

  assign reg_addr_o = entry[15:8];
  assign data_o     = entry[7:0];

endmodule

// File: rtl/iic_cfg_seq.sv
// Walks the sensor power-up table into the I2C write engine, one command per entry,
// retrying NACKed entries and reporting completion or the entry that failed.
module iic_cfg_seq
  import iic_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR   = DEF_DEV_ADDR,
  parameter int         NUM_REGS   = 9,
  parameter int         MAX_RETRY  = 3,
  parameter int         GAP_CYCLES = 1000,
  parameter int         AUTO_START = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [6:0] cmd_dev_addr,
  output logic [7:0] cmd_reg_addr,
  output logic [7:0] cmd_data,
  input  logic       rsp_valid,
  input  logic       rsp_nack,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [3:0] err_index
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_REGS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRY);
  localparam logic             AUTO      = (AUTO_START != 0);

  state_e           state_q,   state_d;
  logic [IDX_W-1:0] idx_q,     idx_d;
  logic [2:0]       retry_q,   retry_d;
  logic [GAP_W-1:0] gap_q,     gap_d;
  logic [3:0]       err_idx_q, err_idx_d;
  logic [3:0]       rom_idx;

  assign rom_idx = 4'(idx_q);

  iic_cfg_rom #(
    .NUM_REGS (NUM_REGS)
  ) u_rom (
    .idx_i      (rom_idx),
    .reg_addr_o (cmd_reg_addr),
    .data_o     (cmd_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      retry_q   <= '0;
      gap_q     <= '0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      retry_q   <= retry_d;
      gap_q     <= gap_d;
      err_idx_q <= err_idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    retry_d   = retry_q;
    gap_d     = gap_q;
    err_idx_d = err_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (AUTO || start) begin
          state_d = ST_ISSUE;
          idx_d   = '0;
          retry_d = '0;
        end
      end
      ST_ISSUE: begin
        if (cmd_ready) state_d = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        if (rsp_valid) begin
          if (!rsp_nack) begin
            retry_d = '0;
            if (idx_q == LAST_IDX) begin
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + 1'b1;
              gap_d   = '0;
              state_d = ST_GAP;
            end
          end else if (retry_q < RETRY_MAX) begin
            retry_d = retry_q + 3'd1;
            gap_d   = '0;
            state_d = ST_GAP;
          end else begin
            err_idx_d = 4'(idx_q);
            state_d   = ST_ERR;
          end
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = ST_ISSUE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_ISSUE;
          idx_d   = '0;
          retry_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_valid    = (state_q == ST_ISSUE);
    busy         = (state_q == ST_ISSUE) || (state_q == ST_WAIT_RSP) || (state_q == ST_GAP);
    done         = (state_q == ST_DONE);
    error        = (state_q == ST_ERR);
    err_index    = err_idx_q;
    cmd_dev_addr = DEV_ADDR;
  end

endmodule
